// File: rtl/program_loader_if.sv
// Memory write port driven by the program loader into the core's shared word memory.
interface program_loader_if;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  logic [31:0] mem_write_val;

  modport master (
    output mem_addr,
    output mem_write_en,
    output mem_write_val
  );

  modport slave (
    input mem_addr,
    input mem_write_en,
    input mem_write_val
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: receives a framed program image over 8N1 UART, writes big-endian words
// into memory from LOAD_BASE, verifies an 8-bit checksum and then releases the core.
module program_loader #(
  parameter int MEM_SIZE     = 256,
  parameter int LOAD_BASE    = 212,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  program_loader_if.master  mem,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_error
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]       MAX_WORDS = 32'(MEM_SIZE - LOAD_BASE);
  localparam logic [31:0]       BASE_ADDR = 32'(LOAD_BASE);

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state_reg;
  logic [1:0]       rx_sync_reg;
  logic             rx_prev_reg;
  logic [CNT_W-1:0] rx_cnt_reg;
  logic [2:0]       rx_bit_reg;
  logic [7:0]       rx_shift_reg;
  logic             byte_valid_reg;
  logic [7:0]       byte_reg;
  logic             frame_err_reg;
  logic             rx_line;

  assign rx_line = rx_sync_reg[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_reg   <= RX_IDLE;
      rx_sync_reg    <= 2'b11;
      rx_prev_reg    <= 1'b1;
      rx_cnt_reg     <= '0;
      rx_bit_reg     <= '0;
      rx_shift_reg   <= '0;
      byte_valid_reg <= 1'b0;
      byte_reg       <= '0;
      frame_err_reg  <= 1'b0;
    end else begin
      rx_sync_reg    <= {rx_sync_reg[0], uart_rx};
      rx_prev_reg    <= rx_line;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_prev_reg && !rx_line) begin
            rx_state_reg <= RX_START;
            rx_cnt_reg   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (rx_cnt_reg == HALF_M1) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_state_reg <= rx_line ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == FULL_M1) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_line, rx_shift_reg[7:1]};
            if (rx_bit_reg == 3'd7) begin
              rx_state_reg <= RX_STOP;
            end else begin
              rx_bit_reg <= rx_bit_reg + 1'b1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg == FULL_M1) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= RX_IDLE;
            if (rx_line) begin
              byte_valid_reg <= 1'b1;
              byte_reg       <= rx_shift_reg;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  // ---------------- Frame loader FSM ----------------
  typedef enum logic [2:0] {
    LD_LEN_HI, LD_LEN_LO, LD_DATA, LD_CSUM, LD_DONE, LD_ERROR
  } ld_state_t;

  ld_state_t   ld_state_reg;
  logic [7:0]  len_hi_reg;
  logic [15:0] word_total_reg;
  logic [15:0] word_idx_reg;
  logic [1:0]  byte_cnt_reg;
  logic [31:0] asm_reg;
  logic [7:0]  sum_reg;
  logic [31:0] mem_addr_reg;
  logic        mem_write_en_reg;
  logic [31:0] mem_write_val_reg;
  logic        core_reset_reg;
  logic        load_done_reg;
  logic        load_error_reg;

  logic [15:0] len_word;
  logic [31:0] new_word;
  logic        terminal;

  assign len_word = {len_hi_reg, byte_reg};
  assign new_word = {asm_reg[23:0], byte_reg};
  assign terminal = (ld_state_reg == LD_DONE) || (ld_state_reg == LD_ERROR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state_reg      <= LD_LEN_HI;
      len_hi_reg        <= '0;
      word_total_reg    <= '0;
      word_idx_reg      <= '0;
      byte_cnt_reg      <= '0;
      asm_reg           <= '0;
      sum_reg           <= '0;
      mem_addr_reg      <= '0;
      mem_write_en_reg  <= 1'b0;
      mem_write_val_reg <= '0;
      core_reset_reg    <= 1'b1;
      load_done_reg     <= 1'b0;
      load_error_reg    <= 1'b0;
    end else begin
      mem_write_en_reg <= 1'b0;
      if (frame_err_reg && !terminal) begin
        ld_state_reg   <= LD_ERROR;
        load_error_reg <= 1'b1;
      end else if (byte_valid_reg) begin
        case (ld_state_reg)
          LD_LEN_HI: begin
            len_hi_reg   <= byte_reg;
            ld_state_reg <= LD_LEN_LO;
          end
          LD_LEN_LO: begin
            word_total_reg <= len_word;
            if ({16'b0, len_word} > MAX_WORDS) begin
              ld_state_reg   <= LD_ERROR;
              load_error_reg <= 1'b1;
            end else if (len_word == 16'd0) begin
              ld_state_reg <= LD_CSUM;
            end else begin
              ld_state_reg <= LD_DATA;
            end
          end
          LD_DATA: begin
            asm_reg      <= new_word;
            sum_reg      <= sum_reg + byte_reg;
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
            if (byte_cnt_reg == 2'd3) begin
              mem_addr_reg      <= BASE_ADDR + {16'b0, word_idx_reg};
              mem_write_val_reg <= new_word;
              mem_write_en_reg  <= 1'b1;
              word_idx_reg      <= word_idx_reg + 1'b1;
              if (word_idx_reg == word_total_reg - 16'd1) begin
                ld_state_reg <= LD_CSUM;
              end
            end
          end
          LD_CSUM: begin
            if (sum_reg == byte_reg) begin
              ld_state_reg   <= LD_DONE;
              load_done_reg  <= 1'b1;
              core_reset_reg <= 1'b0;
            end else begin
              ld_state_reg   <= LD_ERROR;
              load_error_reg <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem.mem_addr      = mem_addr_reg;
  assign mem.mem_write_en  = mem_write_en_reg;
  assign mem.mem_write_val = mem_write_val_reg;
  assign core_reset        = core_reset_reg;
  assign load_done         = load_done_reg;
  assign load_error        = load_error_reg;

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader sitting directly upstream of the single-cycle core and its shared word-addressed memory. It receives a framed program image over a UART line (8N1), assembles 32-bit big-endian words and writes them into memory starting at the core's start PC. It holds the core in reset until the image is fully written and its checksum verified, then releases it.

## Interface
- MEM_SIZE, 256, memory depth in 32-bit words
- LOAD_BASE, 212, first word address written; equals core PC_START
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- uart_rx  in  1  serial input, idle high, asynchronous to clk
- mem_addr  out  32  word address for memory write port
- mem_write_en  out  1  one-cycle write strobe
- mem_write_val  out  32  word to write
- core_reset  out  1  reset to core; high until load succeeds
- load_done  out  1  sticky, image loaded and checksum matched
- load_error  out  1  sticky, framing/length/checksum failure

## Operation
- Receiver: uart_rx through 2-flop synchronizer. Falling edge in idle starts a frame. Start bit re-sampled at CLKS_PER_BIT/2; if high, treat as glitch and return to idle with no byte. 8 data bits LSB first, each sampled mid-bit. Stop bit sampled mid-bit: 1 gives byte_valid pulse (1 cycle) with the byte; 0 gives framing error.
- Frame: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N data bytes (each word big-endian, first byte = bits 31:24), then 1 checksum byte = 8-bit sum mod 256 of all data bytes (header excluded).
- FSM states: LEN_HI -> LEN_LO -> DATA (N>0) or CSUM (N=0) -> DONE or ERROR.
- LEN_LO: if N > MEM_SIZE − LOAD_BASE, go to ERROR; no writes occur.
- DATA: 2-bit byte counter shifts bytes into a 32-bit assembly register; 16-bit word counter. After 4th byte, write word to LOAD_BASE + word index; after word N−1, go to CSUM.
- CSUM: running sum (8-bit, wraps) compared to received byte. Equal: DONE. Unequal: ERROR.
- DONE: load_done=1, core_reset=0. ERROR: load_error=1, core_reset=1. Both terminal until reset; further UART bytes ignored (receiver may run, FSM ignores).
- Framing error in any non-terminal state: go to ERROR. Words already written stay written.
- Reset values: mem_addr=0, mem_write_en=0, mem_write_val=0, core_reset=1, load_done=0, load_error=0; FSM in LEN_HI, all counters and sum 0, receiver idle.
- Reset mid-operation (any state, mid-bit or mid-word): immediate return to reset values; partial word discarded; next load starts with a fresh header.

## Timing
- byte_valid occurs at mid-stop-bit: ~9.5·CLKS_PER_BIT + 2 cycles after the uart_rx falling edge.
- mem_write_en high exactly 1 cycle, the cycle after byte_valid of a word's 4th byte; mem_addr/mem_write_val valid in that same cycle and held until the next write.
- core_reset falls, and load_done rises, the cycle after the checksum byte_valid. load_error rises the cycle after the offending byte_valid or stop-bit sample.
- No back-to-back writes possible (≥4 bytes apart); no write backpressure.
- Core sees reset deassert with memory stable; first fetch at LOAD_BASE.

## Test plan
- CLKS_PER_BIT=4; send 00 02, 20 08 00 05, 00 00 00 00, 2D -> writes 0x20080005@212 and 0x00000000@213, one strobe each; load_done=1, core_reset=0 one cycle after last byte.
- Same image with checksum 2E -> both writes occur, load_error=1, load_done=0, core_reset stays 1.
- Header 00 30 (48 > 44) -> load_error=1 after 2nd byte, mem_write_en never asserts.
- Header 00 00, checksum 00 -> load_done=1, no writes; then extra bytes -> no change.
- Byte with stop bit 0 during DATA -> load_error=1; 1-cycle-wide low glitch on idle line -> no byte, no state change.
- Assert reset after 2 bytes of first word -> all outputs at reset values; full 44-word load then succeeds, last write at address 255.
